// File: rtl/matrix_column_scanner.sv
// Column-multiplexed LED dot-matrix driver: scans a frame-latched image one column per
// dwell slot, with a leading blanking gap per slot and an optional whole-image blink.
module matrix_column_scanner #(
  parameter int unsigned COLS         = 5,
  parameter int unsigned ROWS         = 7,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned BLINK_FRAMES = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 blink,
  input  logic [COLS*ROWS-1:0] image,
  output logic [COLS-1:0]      column_enable,
  output logic [ROWS-1:0]      row_data,
  output logic                 frame_start
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_LIT} state_t;
  typedef enum logic {PH_VISIBLE, PH_HIDDEN} phase_t;

  localparam state_t SLOT_FIRST = (BLANK_CYCLES == 0) ? S_LIT : S_BLANK;

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  logic [COLS*ROWS-1:0]  shadow_q, shadow_d;
  logic [COLS-1:0]       column_enable_q, column_enable_d;
  logic [ROWS-1:0]       row_data_q, row_data_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_wrap;
  logic [COLS-1:0]       col_onehot;
  logic [ROWS-1:0]       col_row;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    frm_d      = frm_q;
    shadow_d   = shadow_q;
    frame_start_d = 1'b0;
    frame_wrap = 1'b0;

    case (state_q)
      S_IDLE: begin
        shadow_d      = image;
        col_d         = '0;
        cnt_d         = '0;
        frame_start_d = 1'b1;
        state_d       = SLOT_FIRST;
      end
      S_BLANK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BLANK_LAST) state_d = S_LIT;
      end
      S_LIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = SLOT_FIRST;
          if (col_q == COL_LAST) begin
            col_d         = '0;
            shadow_d      = image;
            frame_start_d = 1'b1;
            frame_wrap    = 1'b1;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!blink) begin
      frm_d   = '0;
      phase_d = PH_VISIBLE;
    end else if (frame_wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    // Disable overrides everything above, including a coincident frame wrap.
    if (!enable) begin
      state_d       = S_IDLE;
      col_d         = '0;
      cnt_d         = '0;
      frm_d         = '0;
      phase_d       = PH_VISIBLE;
      shadow_d      = shadow_q;
      frame_start_d = 1'b0;
    end
  end

  always_comb begin
    col_onehot = '0;
    col_row    = '1;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_d == COL_W'(c)) begin
        col_onehot[c] = 1'b1;
        col_row       = shadow_d[c*ROWS +: ROWS];
      end
    end
  end

  // Outputs are decoded from next-state so the registered pins line up with the state.
  always_comb begin
    column_enable_d = '0;
    row_data_d      = '1;
    if (state_d == S_LIT && !(blink && phase_d == PH_HIDDEN)) begin
      column_enable_d = col_onehot;
      row_data_d      = col_row;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      phase_q         <= PH_VISIBLE;
      col_q           <= '0;
      cnt_q           <= '0;
      frm_q           <= '0;
      shadow_q        <= '1;
      column_enable_q <= '0;
      row_data_q      <= '1;
      frame_start_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      col_q           <= col_d;
      cnt_q           <= cnt_d;
      frm_q           <= frm_d;
      shadow_q        <= shadow_d;
      column_enable_q <= column_enable_d;
      row_data_q      <= row_data_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign column_enable = column_enable_q;
  assign row_data      = row_data_q;
  assign frame_start   = frame_start_q;

endmodule

// File: doc/matrix_column_scanner.md
Name: matrix_column_scanner

Overview:
Time-multiplexed driver for the LED dot-matrix. It takes a full flattened image of active-low column patterns from the image selector and scans it one column at a time. Each column gets a programmable dwell with a leading blanking gap for anti-ghosting. The image is latched only at frame boundaries so nothing tears mid-frame, and an optional whole-image blink (used for the error state) is provided. It sits between the image selector and the matrix pins.

Parameters:
COLS, 5, number of matrix columns (≥2)
ROWS, 7, number of rows per column
DWELL_CYCLES, 1000, clock cycles per column slot, including blanking (> BLANK_CYCLES)
BLANK_CYCLES, 50, dead-time cycles at the start of each slot (≥0)
BLINK_FRAMES, 100, frames per blink half-period (≥1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
enable  input  1  1 = scan, 0 = blank and idle
blink  input  1  1 = image blinks with period 2*BLINK_FRAMES frames
image  input  COLS*ROWS  column c at [c*ROWS +: ROWS]; per-pixel active-low (1 = LED off)
column_enable  output  COLS  one-hot active-high column drive, all-zero when blank
row_data  output  ROWS  active-low row pattern of the driven column, all-ones when blank
frame_start  output  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- One clock; reset is asynchronous and active-high. All outputs are registered and change only on rising clock edges.
- Reset values:
  - column_enable = 0, row_data = all ones, frame_start = 0.
  - FSM = IDLE, col = 0, slot counter = 0, frame counter = 0, blink phase = visible, shadow image = all ones.
- FSM states: IDLE, BLANK, LIT.
- IDLE:
  - Outputs are blank.
  - An edge sampling enable=1 loads the shadow image from image, sets col = 0 and cnt = 0, and asserts frame_start for that one cycle.
  - Next state is BLANK, or LIT directly if BLANK_CYCLES = 0.
- BLANK:
  - column_enable = 0, row_data = all ones, cnt increments.
  - At cnt = BLANK_CYCLES-1, go to LIT.
- LIT:
  - column_enable = (1 << col) and row_data = shadow[col], unless the blink gate is active.
  - Blink gate active (blink = 1 and phase = hidden): column_enable = 0, row_data = all ones.
  - At cnt = DWELL_CYCLES-1: cnt = 0, col increments, next state is BLANK (or LIT if BLANK_CYCLES = 0).
- Slot length is exactly DWELL_CYCLES cycles per column: BLANK_CYCLES blank, then DWELL_CYCLES-BLANK_CYCLES lit. A full frame is COLS*DWELL_CYCLES cycles.
- Column wrap: col = COLS-1 → 0. On that same transition:
  - the shadow image reloads from image;
  - frame_start pulses for 1 cycle;
  - the frame counter increments.
- Blink phase:
  - When the frame counter reaches BLINK_FRAMES-1 at a wrap, the counter clears and the phase toggles.
  - While blink = 0, the frame counter is held at 0 and the phase is forced visible. Asserting blink therefore always starts visible for a full BLINK_FRAMES frames.
- image changes mid-frame have no visible effect until the next frame_start cycle.
- enable deassert (sampled 0) in any state: the next cycle returns to IDLE with blank outputs. Counters, col and the frame counter clear; the phase resets to visible. Re-enable starts a fresh frame at column 0.
- Reset mid-scan: outputs go blank immediately (asynchronous), with no partial column drive.
- Simultaneous wrap and enable = 0: enable wins; go to IDLE, no frame_start.
- Counter widths are $clog2 of their terminal values; no counter ever exceeds its terminal value.

Test Plan:
Test parameters: COLS=5, ROWS=7, DWELL=8, BLANK=2, BLINK_FRAMES=2.
1. Reset → all outputs blank. Assert enable with the "filling" image: col4=1101111, col3=1011111, col2=0000000, col1=1011111, col0=1101111.
   Required: frame_start on the first cycle; 2 blank cycles; then column_enable=00001 and row_data=1101111 for 6 cycles. Sequence repeats through col4 = 10000 / 1101111; frame_start every 40 cycles.
2. Change image to all ones at cycle 15 (mid-frame) → col2..col4 still show the filling patterns. From the next frame_start, row_data is 1111111 in every lit slot.
3. blink=1 with the "error" image (col2=1010101) → frames 0–1 lit normally, frames 2–3 with column_enable=0 and row_data=all ones, frames 4–5 lit. Deassert blink during a hidden frame → the next LIT slot is visible.
4. BLANK=0 variant → column_enable is never all-zero while enabled; each column is lit for 8 cycles.
5. Deassert enable during col3 LIT → blank on the next cycle. Re-enable → frame_start, and the scan restarts at col0.
6. Assert reset during LIT of col2 → outputs blank asynchronously, before the next edge. After release with enable held 1 → normal frame start at col0.
